// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: the FSM state
// encoding, the supported baud rates and the bit-period divisor function.
package uart_pkg;

  // Wide enough for a 9600-baud divisor at clocks up to about 10 GHz.
  localparam int unsigned DIV_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_fsm_e;

  // Selects 0..4 index this table. Selects 5..7 alias to the fastest rate.
  localparam int unsigned BAUD_RATE [5] = '{9600, 19200, 38400, 57600, 115200};

  // Clock cycles per bit for a baud select. The result is truncated.
  function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_freq,
                                                    input logic [2:0]  sel);
    int unsigned idx;
    int unsigned div;
    idx = {29'd0, sel};
    if (idx > 32'd4) idx = 32'd4;
    div = clk_freq / BAUD_RATE[idx];
    return div[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. It counts 0..divisor-1 while enabled.
// bit_tick marks the last cycle of each bit period.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             enable,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt;

  assign bit_tick = enable && (cnt == (divisor - DIV_W'(1)));

  // Free-run inside a frame, wrap on each bit boundary, and park at zero when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter that sends 8N1 frames at a selectable baud rate.
// The line, done and busy outputs are registered from the FSM state. As a
// result, the line follows the state by one clock cycle.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  input  logic [2:0] baud_set,
  output logic       uart_tx,
  output logic       tx_done,
  output logic       uart_state
);

  localparam logic [DIV_W-1:0] DIV_TBL [8] = '{
    baud_divisor(CLK_FREQ, 3'd0), baud_divisor(CLK_FREQ, 3'd1),
    baud_divisor(CLK_FREQ, 3'd2), baud_divisor(CLK_FREQ, 3'd3),
    baud_divisor(CLK_FREQ, 3'd4), baud_divisor(CLK_FREQ, 3'd5),
    baud_divisor(CLK_FREQ, 3'd6), baud_divisor(CLK_FREQ, 3'd7)
  };

  uart_fsm_e        state;
  logic [7:0]       data_r;
  logic [DIV_W-1:0] divisor_r;
  logic [2:0]       bit_idx;
  logic             bit_tick;
  logic             baud_en;
  logic             accept;

  // The FSM returns to IDLE one cycle before the busy flag drops, which is
  // the tx_done cycle. Gating on uart_state keeps that cycle non-accepting.
  assign accept  = send_en && (state == IDLE) && !uart_state;
  assign baud_en = (state != IDLE);

  uart_baud_gen u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .divisor  (divisor_r),
    .enable   (baud_en),
    .bit_tick (bit_tick)
  );

  // Frame sequencing plus registered line/done/busy outputs, decoded from the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_r     <= '0;
      divisor_r  <= '0;
      bit_idx    <= '0;
      uart_tx    <= 1'b1;
      tx_done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      tx_done    <= (state == STOP) && bit_tick;
      uart_state <= (state != IDLE);
      case (state)
        IDLE:  uart_tx <= 1'b1;
        START: uart_tx <= 1'b0;
        DATA:  uart_tx <= data_r[bit_idx];
        STOP:  uart_tx <= 1'b1;
        default: uart_tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            data_r    <= data_byte;
            divisor_r <= DIV_TBL[baud_set];
            bit_idx   <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_tick) state <= DATA;
        end
        DATA: begin
          if (bit_tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx. The driver predicts each accepted frame
// from the baud table and its own notion of when the transmitter is free.
// A monitor aligns on the busy flag and checks the line cycle by cycle.
module tb_uart_byte_tx;

  localparam int unsigned CLK_FREQ = 50000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_en = 1'b0;
  logic [7:0] data_byte = 8'h00;
  logic [2:0] baud_set = 3'd0;
  logic       uart_tx;
  logic       tx_done;
  logic       uart_state;

  uart_byte_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .send_en    (send_en),
    .data_byte  (data_byte),
    .baud_set   (baud_set),
    .uart_tx    (uart_tx),
    .tx_done    (tx_done),
    .uart_state (uart_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] bits;
    int         period;
    longint     acc_edge;
    logic [7:0] byte_v;
  } frame_t;

  frame_t exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint ecount = 0;
  longint free_edge = 0;
  int     frames_done = 0;
  int     done_seen = 0;
  bit     mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int period_of(input logic [2:0] sel);
    int unsigned rate;
    case (sel)
      3'd0:    rate = 9600;
      3'd1:    rate = 19200;
      3'd2:    rate = 38400;
      3'd3:    rate = 57600;
      default: rate = 115200;
    endcase
    return int'(CLK_FREQ / rate);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) tick();
  endtask

  // Advance until the next rising edge is edge number e.
  task automatic wait_until(input longint e);
    while (ecount + 1 < e) tick();
  endtask

  // Issue a one-cycle request. It is expected to be accepted only when the line is free.
  task automatic send(input logic [7:0] b, input logic [2:0] sel);
    frame_t f;
    data_byte = b;
    baud_set  = sel;
    send_en   = 1'b1;
    tick();
    send_en = 1'b0;
    if (!reset && ecount >= free_edge) begin
      f.bits     = {1'b1, b, 1'b0};
      f.period   = period_of(sel);
      f.acc_edge = ecount;
      f.byte_v   = b;
      exp_q.push_back(f);
      free_edge  = ecount + 10 * f.period + 2;
    end
  endtask

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_seen <= done_seen + 1;
  end

  task automatic check_frame(input frame_t f);
    bit     aborted;
    int     bad;
    logic   badval;
    int     busy_bad;
    longint done_at;
    aborted  = 1'b0;
    busy_bad = 0;
    done_at  = -1;
    check($sformatf("start_latency[%02h]", f.byte_v), 32'(ecount), 32'(f.acc_edge + 1));
    for (int b = 0; b < 10; b++) begin
      bad    = 0;
      badval = 1'b0;
      for (int c = 0; c < f.period; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (uart_tx !== f.bits[b]) begin
          if (bad == 0) badval = uart_tx;
          bad++;
        end
        if (uart_state !== 1'b1) busy_bad++;
        if (tx_done === 1'b1 && done_at < 0) done_at = longint'(b) * f.period + c;
      end
      if (aborted) break;
      check($sformatf("frame[%02h]_bit%0d", f.byte_v, b),
            {31'd0, (bad != 0) ? badval : f.bits[b]}, {31'd0, f.bits[b]});
    end
    if (!aborted) begin
      check($sformatf("frame[%02h]_done_pos", f.byte_v), 32'(done_at), 32'(10 * f.period - 1));
      check($sformatf("frame[%02h]_busy_drop", f.byte_v), 32'(busy_bad), 32'd0);
      @(negedge clk);
      check($sformatf("frame[%02h]_after", f.byte_v),
            {29'd0, uart_state, tx_done, uart_tx}, 32'b001);
      frames_done++;
    end
  endtask

  initial begin : monitor
    frame_t f;
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && uart_state === 1'b1 && !prev) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          check_frame(f);
        end
        mon_busy = 1'b0;
      end
      prev = (uart_state === 1'b1) && !reset;
    end
  end

  initial begin : driver
    longint k;
    int     guard;
    // Reset state
    tick();
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    check("reset_uart_state", {31'd0, uart_state}, 32'd0);
    wait_edges(2);
    reset = 1'b0;
    free_edge = 0;
    wait_edges(5);

    // Basic frame at the fastest rate
    send(8'h55, 3'd4);
    wait_edges(4340 + 20);

    // Slowest rate with MSB ordering
    send(8'h80, 3'd0);
    wait_edges(52080 + 20);

    // Busy protection: the request mid-frame and the one in the tx_done cycle must be ignored
    send(8'hA3, 3'd4);
    k = ecount;
    wait_until(k + 1000);
    send(8'hFF, 3'd4);
    wait_until(k + 4340 + 1);
    send(8'hFF, 3'd4);

    // Back-to-back: request three cycles after tx_done, then the next at the earliest slot
    wait_until(k + 4340 + 3);
    send(8'h00, 3'd4);
    k = ecount;
    wait_until(k + 4342);
    send(8'hFF, 3'd4);
    wait_edges(4340 + 20);

    // Reset during data bit 3 aborts the frame
    send(8'($urandom_range(0, 255)), 3'd4);
    k = ecount;
    wait_until(k + 4 * 434 + 200);
    reset = 1'b1;
    #1;
    check("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("abort_uart_state", {31'd0, uart_state}, 32'd0);
    check("abort_tx_done", {31'd0, tx_done}, 32'd0);
    wait_edges(3);
    reset = 1'b0;
    free_edge = 0;
    wait_edges(3);
    send(8'h3C, 3'd4);
    wait_edges(4340 + 20);

    // Input isolation: change baud_set and data_byte mid-frame
    send(8'($urandom_range(0, 255)), 3'd4);
    wait_edges(600);
    data_byte = ~data_byte;
    baud_set  = 3'd0;
    wait_edges(4340 - 600 + 20);

    // Select aliasing and a random fast select
    send(8'($urandom_range(0, 255)), 3'd7);
    wait_edges(4340 + 20);
    send(8'($urandom_range(0, 255)), 3'($urandom_range(4, 7)));
    wait_edges(4340 + 20);

    guard = 0;
    while ((exp_q.size() > 0 || mon_busy) && guard < 60000) begin
      tick();
      guard++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("monitor_idle", {31'd0, mon_busy}, 32'd0);
    wait_edges(2);
    check("tx_done_count", 32'(done_seen), 32'(frames_done));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
